// File: rtl/bpu_update_ctrl.sv
// rtl/bpu_update_ctrl.sv - branch resolution update queue and mispredict recovery FSM
// Optional macro BPU_UPDATE_STATS_EN builds saturating branch/mispredict counters.
module bpu_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic            res_taken,
    input  logic            res_pred,
    input  logic [PC_W-1:0] res_target,
    input  logic [PC_W-1:0] res_fallthru,
    input  logic            stall,
    output logic            res_ready,
    output logic            upd_branch,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken,
    output logic            flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispred_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            empty, full, accept, mispred;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign mispred    = (res_taken != res_pred);
    assign upd_branch = !empty && !stall;
    assign upd_pc     = mem[rd_ptr][PC_W:1];
    assign upd_taken  = mem[rd_ptr][0];

    always_comb begin
        state_nxt      = state;
        res_ready      = 1'b0;
        accept         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                res_ready = !full;
                accept    = res_valid && !full;
                if (accept && mispred)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_nxt      = RECOVER;
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (upd_branch)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, upd_branch})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Target is captured at accept so it is stable throughout FLUSH and held afterwards.
            if (accept && mispred)
                redirect_pc <= res_taken ? res_target : res_fallthru;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {res_pc, res_taken};
    end

`ifdef BPU_UPDATE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (accept && branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (accept && mispred && mispred_cnt != 16'hFFFF)
                mispred_cnt <= mispred_cnt + 16'd1;
        end
    end
`else
    assign branch_cnt  = 16'd0;
    assign mispred_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb/tb_bpu_update_ctrl.sv - directed and randomized check of bpu_update_ctrl against a queue model
module tb_bpu_update_ctrl;

    localparam int DEPTH = 4;
    localparam int PC_W  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            res_valid, res_taken, res_pred, stall;
    logic [PC_W-1:0] res_pc, res_target, res_fallthru;
    logic            res_ready, upd_branch, upd_taken, flush, redirect_valid;
    logic [PC_W-1:0] upd_pc, redirect_pc;
    logic [15:0]     branch_cnt, mispred_cnt;

    bpu_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_pred(res_pred),
        .res_target(res_target), .res_fallthru(res_fallthru), .stall(stall),
        .res_ready(res_ready), .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending updates in order, cycles left of the redirect window
    // (2 = redirect cycle, 1 = wrong-path cycle), last redirect target, statistics.
    logic [PC_W:0]   mq[$];
    int              blk = 0;
    logic [PC_W-1:0] m_redir = '0;
    int              m_br = 0;
    int              m_mp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef BPU_UPDATE_STATS_EN
        chk("branch_cnt", 32'(branch_cnt), m_br);
        chk("mispred_cnt", 32'(mispred_cnt), m_mp);
`else
        chk("branch_cnt", 32'(branch_cnt), 0);
        chk("mispred_cnt", 32'(mispred_cnt), 0);
`endif
    endtask

    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic tk, input logic pr,
                        input logic [PC_W-1:0] tg, input logic [PC_W-1:0] ft, input logic st);
        logic e_ready, e_upd;
        res_valid = v; res_pc = pc; res_taken = tk; res_pred = pr;
        res_target = tg; res_fallthru = ft; stall = st;
        #2;
        e_ready = (blk == 0) && (mq.size() < DEPTH);
        e_upd   = (mq.size() > 0) && !st;
        chk("res_ready", 32'(res_ready), 32'(e_ready));
        chk("upd_branch", 32'(upd_branch), 32'(e_upd));
        if (e_upd) begin
            chk("upd_pc", 32'(upd_pc), 32'(mq[0][PC_W:1]));
            chk("upd_taken", 32'(upd_taken), 32'(mq[0][0]));
        end
        chk("flush", 32'(flush), 32'(blk == 2));
        chk("redirect_valid", 32'(redirect_valid), 32'(blk == 2));
        chk("redirect_pc", 32'(redirect_pc), 32'(m_redir));
        chk_stats();
        @(posedge clk);
        if (e_upd)
            void'(mq.pop_front());
        if (blk > 0)
            blk--;
        if (v && e_ready) begin
            mq.push_back({pc, tk});
            if (m_br < 65535) m_br++;
            if (tk != pr) begin
                if (m_mp < 65535) m_mp++;
                blk     = 2;
                m_redir = tk ? tg : ft;
            end
        end
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, st);
    endtask

    initial begin
        reset = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_pred = 1'b0;
        res_target = '0; res_fallthru = '0; stall = 1'b0;
        #2;
        chk("rst_upd_branch", 32'(upd_branch), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redirect_valid", 32'(redirect_valid), 0);
        chk("rst_redirect_pc", 32'(redirect_pc), 0);
        chk_stats();
        #10 reset = 1'b1;
        #1 chk("ready_after_reset", 32'(res_ready), 1);
        @(posedge clk); #1;

        // correct prediction: one-cycle update latency, no flush
        step(1'b1, 8'h10, 1'b1, 1'b1, 8'h55, 8'h11, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // mispredict: flush/redirect for one cycle, wrong-path resolution ignored, then IDLE
        step(1'b1, 8'h20, 1'b1, 1'b0, 8'h40, 8'h21, 1'b0);
        step(1'b1, 8'h31, 1'b0, 1'b0, 8'h32, 8'h33, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 8'h35, 8'h36, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // stall fills the queue; fifth resolution refused, then in-order drain
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h60 + 8'(i), 1'(i), 1'(i), 8'h00, 8'h01, 1'b1);
        for (int i = 0; i < 5; i++)
            idle(1'b0);

        // full queue with stall released: pop only, accept on the next cycle
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 8'h00, 8'h01, 1'b1);
        step(1'b1, 8'h70, 1'b1, 1'b1, 8'h00, 8'h71, 1'b0);
        step(1'b1, 8'h70, 1'b1, 1'b1, 8'h00, 8'h71, 1'b0);
        for (int i = 0; i < 6; i++)
            idle(1'b0);

        // reset asserted during FLUSH with three entries pending
        step(1'b1, 8'h80, 1'b1, 1'b1, 8'h00, 8'h81, 1'b1);
        step(1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 8'h82, 1'b1);
        step(1'b1, 8'h82, 1'b1, 1'b0, 8'h90, 8'h83, 1'b1);
        chk("pre_rst_flush", 32'(flush), 1);
        res_valid = 1'b0; stall = 1'b0;
        reset = 1'b0;
        #1;
        mq.delete(); blk = 0; m_redir = '0; m_br = 0; m_mp = 0;
        chk("midrst_upd_branch", 32'(upd_branch), 0);
        chk("midrst_flush", 32'(flush), 0);
        chk("midrst_redirect_valid", 32'(redirect_valid), 0);
        chk("midrst_redirect_pc", 32'(redirect_pc), 0);
        chk_stats();
        #1 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            idle(1'b0);

        // statistics: three branches, one mispredicted (not-taken path redirect)
        step(1'b1, 8'hC0, 1'b1, 1'b1, 8'h00, 8'hC1, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b1, 8'hEE, 8'hC2, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0);
        idle(1'b0);
`ifdef BPU_UPDATE_STATS_EN
        chk("stats_branch3", 32'(branch_cnt), 3);
        chk("stats_mispred1", 32'(mispred_cnt), 1);
`else
        chk("stats_branch0", 32'(branch_cnt), 0);
        chk("stats_mispred0", 32'(mispred_cnt), 0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic tk;
            tk = 1'($urandom);
            step($urandom_range(0, 3) != 0, 8'($urandom), tk,
                 ($urandom_range(0, 3) == 0) ? !tk : tk,
                 8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 8; i++)
            idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
